// File: rtl/alu_mdu_if.sv
// alu_mdu_if: start/busy/done handshake bundle between the control unit
// (master) and the multi-cycle multiply/divide unit (slave).
//   start      request, taken on a rising edge while busy=0
//   op[2:0]    op[1:0]: 00 MUL lo, 01 MUL hi, 10 DIV, 11 REM; op[2]: signed
//   a, b       operands, sampled when the request is taken
//   busy       operation in flight
//   done       one-cycle completion pulse
//   result     registered result, held until the next completion
//   zero_flag  registered (result == 0)
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero_flag;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero_flag
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero_flag
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle multiply/divide unit, one bit per clock.
// Shift-add multiply (low/high product) and restoring divide (quotient/
// remainder); WIDTH iterations plus one finish cycle, so the result lands
// WIDTH+1 clocks after the accept edge.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    alu_mdu_if.slave (start/op/a/b in, busy/done/result/zero_flag out)
// Build option: MDU_SIGNED_EN -- when defined, op[2]=1 selects two's
// complement operation; when undefined op[2] is ignored and no sign logic
// is built.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic      clk,
  input logic      reset,
  alu_mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH:0]   acc;      // {borrow/carry, upper half, lower half}
  logic [WIDTH-1:0]   opnd;     // multiplicand (MUL) or divisor (DIV/REM)
  logic [1:0]         op_q;
  logic               b_zero;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   res_q;
  logic               zf_q;
  logic               done_q;

  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH:0]   div_shift, acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin_val;

  assign accept = bus.start && (state == IDLE);

`ifdef MDU_SIGNED_EN
  logic neg_a_in, neg_b_in;
  logic neg_q, neg_r;   // negate product/quotient; negate remainder
  assign neg_a_in = bus.op[2] & bus.a[WIDTH-1];
  assign neg_b_in = bus.op[2] & bus.b[WIDTH-1];
  assign mag_a    = neg_a_in ? (~bus.a + 1'b1) : bus.a;
  assign mag_b    = neg_b_in ? (~bus.b + 1'b1) : bus.b;
`else
  logic unused_op_sign;
  assign unused_op_sign = bus.op[2];
  assign mag_a = bus.a;
  assign mag_b = bus.b;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration. MUL keeps the multiplier in the lower half and shifts
  // it out LSB-first while the product grows into the upper half. DIV keeps
  // the dividend in the lower half; quotient bits enter at bit 0 as dividend
  // bits leave into the remainder. The W+1-bit trial difference has bit W
  // set exactly when the subtract borrowed.
  always_comb begin
    mul_sum   = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
    div_shift = {acc[2*WIDTH-1:0], 1'b0};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd};
    acc_step  = acc;
    if (op_q[1]) begin
      if (!div_diff[WIDTH]) acc_step = {div_diff, div_shift[WIDTH-1:1], 1'b1};
      else                  acc_step = div_shift;
    end else begin
      if (acc[0]) acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH:1]};
    end
  end

  // Output selection and sign correction. With b=0 the restoring loop
  // already leaves the dividend as remainder; only the quotient is forced.
  always_comb begin
    prod = acc[2*WIDTH-1:0];
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
    if (neg_q) begin
      prod = ~prod + 1'b1;
      quo  = ~quo + 1'b1;
    end
    if (neg_r) rem = ~rem + 1'b1;
`endif
    if (b_zero) quo = '1;
    case (op_q)
      2'b00:   fin_val = prod[WIDTH-1:0];
      2'b01:   fin_val = prod[2*WIDTH-1:WIDTH];
      2'b10:   fin_val = quo;
      default: fin_val = rem;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      b_zero <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
      zf_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q   <= bus.op[1:0];
          b_zero <= (bus.b == '0);
          cnt    <= '0;
          // Accumulator starts cleared apart from the operand to be shifted
          if (bus.op[1]) begin
            acc  <= {{(WIDTH+1){1'b0}}, mag_a};
            opnd <= mag_b;
          end else begin
            acc  <= {{(WIDTH+1){1'b0}}, mag_b};
            opnd <= mag_a;
          end
`ifdef MDU_SIGNED_EN
          neg_q <= neg_a_in ^ neg_b_in;
          neg_r <= neg_a_in;
`endif
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          res_q  <= fin_val;
          zf_q   <= (fin_val == '0);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.zero_flag = zf_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu (WIDTH=32). The driver pushes
// the expected result and accept cycle for every accepted request; a
// monitor on the falling edge pops and compares on every done pulse.
module tb_alu_mdu;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] exp;
    int           acc_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  sb_t  sb[$];

  alu_mdu_if #(.WIDTH(W)) bus ();
  alu_mdu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: plain wide arithmetic on the operation's definition
  function automatic logic [W-1:0] ref_calc(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    longint unsigned ua, ub, up;
    longint          sa, sb_, sp;
    logic [63:0]     p;
    bit              sgn;
    ua = 64'(a); ub = 64'(b);
    sa = longint'(signed'(a)); sb_ = longint'(signed'(b));
    sgn = 1'b0;
`ifdef MDU_SIGNED_EN
    sgn = op[2];
`endif
    if (!op[1]) begin
      if (sgn) begin sp = sa * sb_; p = 64'(sp); end
      else     begin up = ua * ub;  p = up;      end
      return op[0] ? p[63:32] : p[31:0];
    end
    if (b == '0) return op[0] ? a : '1;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? '0 : a;
      sp = op[0] ? (sa % sb_) : (sa / sb_);
      p  = 64'(sp);
    end else begin
      p = op[0] ? (ua % ub) : (ua / ub);
    end
    return p[31:0];
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done && bus.busy) chk("done_with_busy", 32'(bus.busy), 32'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("result", bus.result, e.exp);
          chk("zero_flag", 32'(bus.zero_flag), 32'(e.exp == '0));
          chk("latency", 32'(cyc - e.acc_cyc), 32'(W + 1));
        end
      end
    end
  end

  // Issue one request as soon as the unit is free; expectation is pushed
  // on the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("wait_idle_timeout", 32'd1, 32'd0);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    sb.push_back('{exp: exp, acc_cyc: cyc});
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
  endtask

  task automatic poke_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 50));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    int           n;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zf", 32'(bus.zero_flag), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    issue(3'b000, 32'd3, 32'd5, 32'h0000_000F);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'b010, 32'd100, 32'd7, 32'd14);
    issue(3'b011, 32'd100, 32'd7, 32'd2);
    issue(3'b010, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    issue(3'b011, 32'h1234, 32'd0, 32'h1234);
    issue(3'b000, 32'd0, 32'd9, 32'd0);

    // Requests while busy must be ignored
    issue(3'b010, 32'd100, 32'd7, 32'd14);
    repeat (4) @(posedge clk);
    poke_start(32'd55, 32'd0);
    repeat (14) @(posedge clk);
    poke_start(32'd999, 32'd3);

    // Reset partway through a multiply
    issue(3'b000, 32'd11, 32'd13, 32'd143);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_zf", 32'(bus.zero_flag), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    issue(3'b000, 32'd6, 32'd7, 32'd42);

`ifdef MDU_SIGNED_EN
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue(3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    issue(3'b101, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
`else
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    issue(3'b101, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rnd_opnd();
      rb  = rnd_opnd();
      issue(rop, ra, rb, ref_calc(rop, ra, rb));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (40) @(negedge clk);
    chk("idle_at_end", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

- Parametrised, multi-cycle multiply/divide companion to the single-cycle ALU.
- Performs WIDTH-bit multiply (low/high product), divide and remainder by iterative shift-add and restoring division, one bit per clock.
- Uses a start/busy/done handshake and holds the registered result and zero flag until the next operation.
- Sits beside the ALU in the execute stage; the control unit stalls the core while busy is high.

## Interface

Parameters:
- WIDTH, default 32: operand and result width in bits; must be ≥ 4.
- CNT_W, default $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where busy=0.
- op  input  3  op[1:0]: 00 MUL low, 01 MUL high, 10 DIV quotient, 11 REM. op[2]: signed (see Configuration).
- a  input  WIDTH  multiplicand / dividend; sampled at accept.
- b  input  WIDTH  multiplier / divisor; sampled at accept.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse; result valid.
- result  output  WIDTH  registered result, held until the next completion.
- zero_flag  output  1  registered (result == 0), updated together with result.

## Operation

- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, zero_flag=0; internal registers cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN on start:
  - Latch a, b and op.
  - Clear the 2*WIDTH-bit accumulator/remainder.
  - Counter=0.
- RUN, one iteration per cycle:
  - MUL: if multiplier LSB is set, add the multiplicand into the upper half; shift right.
  - DIV: shift the remainder left, bringing in the next dividend bit; trial-subtract the divisor; if non-negative, keep the difference and set the quotient bit.
  - Counter increments each cycle. RUN -> FIN after WIDTH iterations.
- FIN:
  - Select the output: product[WIDTH-1:0], product[2W-1:W], quotient or remainder.
  - Apply sign correction when signed mode is enabled.
  - Register result and zero_flag, pulse done, then go to IDLE.
- Divide by zero (b=0): quotient = all ones; remainder = a. No trap.
- Signed overflow (a = most negative, b = -1, DIV/REM): quotient = a; remainder = 0.
- Start while busy: ignored; latched operands are unaffected.
- Start on the done cycle: accepted (busy=0 in that cycle); back-to-back operations carry no dead cycle.
- Reset mid-operation: aborts immediately to IDLE with the reset values above; no done pulse.
- All arithmetic is modulo 2^WIDTH on outputs; the internal accumulator is 2*WIDTH+1 bits to hold the subtract borrow.

## Timing

- Accept edge N (start=1, busy=0): busy=1 from just after edge N.
- Edges N+1 .. N+WIDTH: iterations. FSM enters FIN after edge N+WIDTH.
- Edge N+WIDTH+1: result and zero_flag update; done=1 and busy=0 for one cycle.
- Latency: WIDTH+1 clocks from accept edge to result-valid edge; 33 for WIDTH=32.
- done is never high together with busy.
- result and zero_flag are stable outside completion edges.

## Configuration

- MDU_SIGNED_EN defined:
  - op[2]=1 selects two's-complement operation.
  - Operands are converted to magnitudes at accept.
  - In FIN: product negated if the signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
  - MUL high returns the signed high half.
  - The overflow rule applies.
- MDU_SIGNED_EN undefined:
  - op[2] is ignored and all operations are unsigned.
  - Sign/negate logic is not synthesised.

## Test plan

- WIDTH=32, MUL op=000, a=3, b=5: busy for 33 cycles, then done pulse, result=0x0000000F, zero_flag=0.
- MUL high op=001, a=b=0xFFFFFFFF: result=0xFFFFFFFE. Then DIV op=010, a=100, b=7, started on the done cycle: result=14; REM op=011: result=2.
- Divide by zero, a=0x1234, b=0: DIV gives 0xFFFFFFFF; REM gives 0x1234. MUL a=0, b=9: result=0, zero_flag=1.
- start re-asserted with new operands at cycles 5 and 20 of a running DIV 100/7: ignored, result=14, exactly one done pulse.
- reset asserted at cycle 10 of a MUL: busy, done, result and zero_flag go to 0 asynchronously; no done pulse; the next MUL 6*7 gives 42.
- With MDU_SIGNED_EN, op=110, a=-7, b=2: result=0xFFFFFFFD; op=111: result=0xFFFFFFFF. a=0x80000000, b=-1, DIV: result=0x80000000. Without the macro, op=110, a=0xFFFFFFF9, b=2: result=0x7FFFFFFC.
